// File: rtl/soml_min_selector.sv
// soml_min_selector: decision stage of the SOML detector.
// Latches one trace per search, computes a saturated ML metric for each
// streamed constellation candidate (metric = energy - 2*Re(trace*conj(x))),
// tracks the minimum and reports the winning index/metric once per search.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start                      begin (or restart) a search, latches trace_r/trace_i
//   trace_r, trace_i           trace value, Q-format signed
//   cand_valid / cand_ready    candidate handshake
//   cand_xr, cand_xi           candidate symbol, Q-format signed
//   cand_energy                precomputed candidate energy term (signed)
//   busy                       search in progress
//   result_valid               one-cycle pulse, best_idx/best_metric updated
//   best_idx, best_metric      winning candidate index and its metric
module soml_min_selector #(
  parameter int unsigned N         = 16,
  parameter int unsigned Q         = 8,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned NUM_CAND  = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N-1:0]         trace_r,
  input  logic [N-1:0]         trace_i,
  input  logic                 cand_valid,
  output logic                 cand_ready,
  input  logic [N-1:0]         cand_xr,
  input  logic [N-1:0]         cand_xi,
  input  logic [ACC_WIDTH-1:0] cand_energy,
  output logic                 busy,
  output logic                 result_valid,
  output logic [IDX_W-1:0]     best_idx,
  output logic [ACC_WIDTH-1:0] best_metric
);

  localparam int unsigned CNT_W = $clog2(NUM_CAND + 1);
  localparam int unsigned PW    = 2 * N + 1;
  localparam int unsigned MW    = ACC_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [N-1:0]         trace_r_q, trace_i_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        s1_valid_q, s1_last_q;
  logic [IDX_W-1:0]            s1_idx_q;
  logic signed [ACC_WIDTH-1:0] s1_metric_q;
  logic                        min_valid_q;
  logic [IDX_W-1:0]            min_idx_q;
  logic signed [ACC_WIDTH-1:0] min_metric_q;
  logic                        busy_q, cand_ready_q, result_valid_q;
  logic [IDX_W-1:0]            best_idx_q;
  logic [ACC_WIDTH-1:0]        best_metric_q;

  logic                        hs_c, last_hs_c, result_c, take_c;
  logic signed [2*N-1:0]       prod_r_c, prod_i_c;
  logic signed [PW-1:0]        prod_sum_c, shifted_c;
  logic signed [MW-1:0]        metric_wide_c;
  logic signed [ACC_WIDTH-1:0] metric_sat_c;
  logic signed [ACC_WIDTH-1:0] new_min_metric_c;
  logic [IDX_W-1:0]            new_min_idx_c;

  assign cand_ready   = cand_ready_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign best_idx     = best_idx_q;
  assign best_metric  = best_metric_q;

  // Stage-1 arithmetic: full-precision dot product, rescale, saturate
  always_comb begin
    prod_r_c      = trace_r_q * $signed(cand_xr);
    prod_i_c      = trace_i_q * $signed(cand_xi);
    prod_sum_c    = PW'(prod_r_c) + PW'(prod_i_c);
    shifted_c     = prod_sum_c >>> (Q - 1);
    metric_wide_c = MW'($signed(cand_energy)) - MW'(shifted_c);
    if (metric_wide_c[MW-1] != metric_wide_c[MW-2]) begin
      metric_sat_c = metric_wide_c[MW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      metric_sat_c = metric_wide_c[ACC_WIDTH-1:0];
    end
  end

  // Stage-2 compare: first candidate loads unconditionally, strict less-than keeps lower index on ties
  always_comb begin
    take_c           = s1_valid_q && (!min_valid_q || (s1_metric_q < min_metric_q));
    new_min_metric_c = take_c ? s1_metric_q : min_metric_q;
    new_min_idx_c    = take_c ? s1_idx_q : min_idx_q;
  end

  // Next-state and control decode
  always_comb begin
    state_d   = state_q;
    hs_c      = cand_valid && cand_ready_q;
    last_hs_c = hs_c && (cnt_q == CNT_W'(NUM_CAND - 1));
    cnt_d     = cnt_q;
    result_c  = 1'b0;

    if (start) begin
      // Start aborts any search in flight, including one about to report
      state_d = SEARCH;
      cnt_d   = '0;
    end else begin
      if (hs_c) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      case (state_q)
        IDLE:    state_d = IDLE;
        SEARCH:  if (last_hs_c) state_d = DRAIN;
        DRAIN: begin
          result_c = s1_valid_q && s1_last_q;
          if (result_valid_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      trace_r_q      <= '0;
      trace_i_q      <= '0;
      cnt_q          <= '0;
      s1_valid_q     <= 1'b0;
      s1_last_q      <= 1'b0;
      s1_idx_q       <= '0;
      s1_metric_q    <= '0;
      min_valid_q    <= 1'b0;
      min_idx_q      <= '0;
      min_metric_q   <= '0;
      busy_q         <= 1'b0;
      cand_ready_q   <= 1'b0;
      result_valid_q <= 1'b0;
      best_idx_q     <= '0;
      best_metric_q  <= '0;
    end else begin
      cnt_q          <= cnt_d;
      busy_q         <= (state_d != IDLE);
      cand_ready_q   <= (state_d == SEARCH) && (cnt_d < CNT_W'(NUM_CAND));
      result_valid_q <= result_c;
      if (result_c) begin
        best_idx_q    <= new_min_idx_c;
        best_metric_q <= new_min_metric_c;
      end

      if (start) begin
        trace_r_q   <= $signed(trace_r);
        trace_i_q   <= $signed(trace_i);
        s1_valid_q  <= 1'b0;
        s1_last_q   <= 1'b0;
        min_valid_q <= 1'b0;
      end else begin
        s1_valid_q <= hs_c;
        if (hs_c) begin
          s1_metric_q <= metric_sat_c;
          s1_idx_q    <= IDX_W'(cnt_q);
          s1_last_q   <= last_hs_c;
        end
        if (take_c) begin
          min_valid_q  <= 1'b1;
          min_metric_q <= new_min_metric_c;
          min_idx_q    <= new_min_idx_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_soml_min_selector.sv
// Directed bench for soml_min_selector with a result scoreboard.
module tb_soml_min_selector;

  localparam int unsigned N  = 16;
  localparam int unsigned Q  = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned IW = 2;
  localparam longint     ACC_MIN = -(64'sd1 <<< (AW - 1));

  logic          clk = 1'b0;
  logic          rst, start;
  logic [N-1:0]  trace_r, trace_i, cand_xr, cand_xi;
  logic          cand_valid, cand_ready;
  logic [AW-1:0] cand_energy;
  logic          busy, result_valid;
  logic [IW-1:0] best_idx;
  logic [AW-1:0] best_metric;

  soml_min_selector #(.N(N), .Q(Q), .ACC_WIDTH(AW), .NUM_CAND(NC), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .trace_r(trace_r), .trace_i(trace_i),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_xr(cand_xr),
    .cand_xi(cand_xi), .cand_energy(cand_energy), .busy(busy),
    .result_valid(result_valid), .best_idx(best_idx), .best_metric(best_metric)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint idx;
    longint metric;
    int     cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   hs_cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every result pulse must match the oldest expectation
  always @(negedge clk) begin
    if (result_valid) begin
      check("sb_nonempty", longint'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("best_idx", longint'(best_idx), e.idx);
        check("best_metric", longint'($signed(best_metric)), e.metric);
        check("result_cycle", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input int tr, input int ti);
    cand_valid = 1'b0;
    trace_r    = N'(tr);
    trace_i    = N'(ti);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", longint'(busy), 1);
    check("start_ready", longint'(cand_ready), 1);
  endtask

  // Presents one candidate and waits (bounded) for its handshake; leaves cand_valid high
  task automatic send_cand(input int xr, input int xi, input longint e);
    int waited = 0;
    cand_xr     = N'(xr);
    cand_xi     = N'(xi);
    cand_energy = AW'(e);
    cand_valid  = 1'b1;
    while (!cand_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!cand_ready) begin
      check("hs_timeout", longint'(cand_ready), 1);
      cand_valid = 1'b0;
    end else begin
      hs_cyc = cyc;
      @(posedge clk); #1;
    end
  endtask

  // Candidate sets: 0 = spec basic set, 1 = all-equal, 2 = saturation
  task automatic send_set(input int set, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps && i > 0) begin
        cand_valid = 1'b0;
        @(posedge clk); #1;
      end
      case (set)
        0: case (i)
             0: send_cand(256, 0, 256);
             1: send_cand(-256, 0, 256);
             2: send_cand(0, 256, 256);
             default: send_cand(0, -256, 256);
           endcase
        1: send_cand(0, 0, 100);
        default: send_cand(32767, 32767, ACC_MIN);
      endcase
    end
  endtask

  // Called in the cycle after the last handshake
  task automatic finish_search(input longint eidx, input longint emet);
    exp_t e;
    e.idx = eidx; e.metric = emet; e.cyc = hs_cyc + 2;
    sb.push_back(e);
    check("no_extra_ready_k1", longint'(cand_ready), 0);
    @(posedge clk); #1;
    check("busy_k2", longint'(busy), 1);
    check("pulse_k2", longint'(result_valid), 1);
    @(posedge clk); #1;
    check("busy_k3", longint'(busy), 0);
    check("pulse_k3", longint'(result_valid), 0);
    check("no_extra_ready_k3", longint'(cand_ready), 0);
    check("hold_metric", longint'($signed(best_metric)), emet);
    cand_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cand_valid = 1'b0;
    trace_r = '0; trace_i = '0; cand_xr = '0; cand_xi = '0; cand_energy = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", longint'(busy), 0);
    check("rst_ready", longint'(cand_ready), 0);
    check("rst_pulse", longint'(result_valid), 0);
    check("rst_idx", longint'(best_idx), 0);
    check("rst_metric", longint'(best_metric), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: basic search
    do_start(512, 0);
    send_set(0, 4, 1'b0);
    finish_search(0, -768);

    // 2: all metrics equal
    do_start(512, 0);
    send_set(1, 4, 1'b0);
    finish_search(0, 100);

    // 3: imaginary-path selection
    do_start(0, -512);
    send_set(0, 4, 1'b0);
    finish_search(3, -768);

    // 4: valid gaps
    do_start(512, 0);
    send_set(0, 4, 1'b1);
    finish_search(0, -768);

    // 5a: restart after two candidates, then a full search on the new trace
    do_start(0, -512);
    send_set(0, 2, 1'b0);
    do_start(512, 0);
    send_set(0, 4, 1'b0);
    finish_search(0, -768);

    // 5b: reset after three candidates
    do_start(0, -512);
    send_set(0, 3, 1'b0);
    cand_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy", longint'(busy), 0);
    check("rst_mid_ready", longint'(cand_ready), 0);
    check("rst_mid_pulse", longint'(result_valid), 0);
    check("rst_mid_idx", longint'(best_idx), 0);
    check("rst_mid_metric", longint'(best_metric), 0);
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_quiet", longint'(busy), 0);

    // 6: saturation
    do_start(32767, 32767);
    send_set(2, 4, 1'b0);
    finish_search(0, ACC_MIN);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", longint'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
